bldc_drive_sequencer: RTL

//  Sequences one BLDC commutation stage by generating its pwm, dir and brake inputs from a clocked controller.
//  - Creates a counter-based PWM from a duty command.
//  - Performs safe direction reversal: brake, wait for the rotor to stall, then switch dir.
//  - Monitors Hall sensors for invalid or illegal codes and latches a fault.
//  - Measures Hall edge period for speed feedback.

---
 rtl/bldc_pkg.sv | 23 ++
 rtl/bldc_hall_monitor.sv | 81 ++++++++
 rtl/bldc_drive_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared types, constants and helpers for the BLDC drive sequencer
// Purpose: sequencer state encoding, illegal Hall codes, Hall adjacency check.
// Ports: none (package).
package bldc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [2:0] HALL_BAD0 = 3'b000;
    localparam logic [2:0] HALL_BAD1 = 3'b111;

    // A legal commutation step flips exactly one sensor.
    function automatic logic hall_adjacent(input logic [2:0] old_code, input logic [2:0] new_code);
        logic [2:0] diff;
        diff = old_code ^ new_code;
        return (diff == 3'b001) || (diff == 3'b010) || (diff == 3'b100);
    endfunction

endpackage

// File: rtl/bldc_hall_monitor.sv
// rtl/bldc_hall_monitor.sv - Hall synchronizer, edge timing, stall and fault detection
// Purpose: synchronizes the raw Hall inputs, times the interval between edges,
//          flags a stalled rotor and raises a combinational fault condition.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   hall_in[2:0] raw asynchronous Hall sensors
//   hall[2:0]    synchronized Hall code (registered)
//   hall_period  clk cycles between the last two valid edges, saturating at 16'hFFFF
//   stalled      no Hall edge for at least STALL_CLKS cycles
//   fault_cond   illegal code held two clks, or a multi-bit jump on an edge
module bldc_hall_monitor
    import bldc_pkg::*;
#(
    parameter int STALL_CLKS = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hall_in,
    output logic [2:0]  hall,
    output logic [15:0] hall_period,
    output logic        stalled,
    output logic        fault_cond
);

    localparam logic [19:0] STALL_LIM = 20'(STALL_CLKS);

    logic [2:0]  sync1;
    logic [2:0]  hall_prev;
    logic        bad_d;
    logic [19:0] edge_cnt;
    logic        hall_edge;
    logic        hall_bad;
    logic        step_ok;
    logic        valid_edge;
    logic [20:0] elapsed;

    assign hall_edge  = (hall != hall_prev);
    assign hall_bad   = (hall == HALL_BAD0) || (hall == HALL_BAD1);
    assign step_ok    = hall_adjacent(hall_prev, hall);
    assign valid_edge = hall_edge && step_ok && !hall_bad
                        && (hall_prev != HALL_BAD0) && (hall_prev != HALL_BAD1);
    assign stalled    = (edge_cnt >= STALL_LIM);
    assign fault_cond = (hall_bad && bad_d) || (hall_edge && !step_ok);

    // The edge cycle itself is one of the elapsed clocks, so edges N clks
    // apart report N.
    assign elapsed = {1'b0, edge_cnt} + 21'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 3'b000;
            hall      <= 3'b000;
            hall_prev <= 3'b000;
            bad_d     <= 1'b0;
        end else begin
            sync1     <= hall_in;
            hall      <= sync1;
            hall_prev <= hall;
            bad_d     <= hall_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 20'd0;
        end else if (hall_edge) begin
            edge_cnt <= 20'd0;
        end else if (edge_cnt != 20'hFFFFF) begin
            edge_cnt <= edge_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_period <= 16'hFFFF;
        end else if (valid_edge) begin
            hall_period <= (elapsed > 21'h00FFFF) ? 16'hFFFF : elapsed[15:0];
        end
    end

endmodule

// File: rtl/bldc_drive_sequencer.sv
// rtl/bldc_drive_sequencer.sv - PWM, safe reversal and Hall fault sequencing for one BLDC stage
// Purpose: generates pwm/dir/brake for a combinational commutation stage from a
//          duty command, brakes and waits for stall before reversing, latches Hall faults.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             drive enable
//   duty[CNT_W]    requested on-time in clk cycles per PWM period
//   dir_req        requested direction
//   brake_req      explicit brake request
//   hall_in[2:0]   raw Hall sensors
//   fault_clr      fault clear, honoured only with en=0
//   pwm, dir, brake, hall, fault, hall_period   registered outputs
module bldc_drive_sequencer
    import bldc_pkg::*;
#(
    parameter int CNT_W         = 10,
    parameter int PERIOD        = 1000,
    parameter int BRAKE_PERIODS = 64,
    parameter int STALL_CLKS    = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic             dir_req,
    input  logic             brake_req,
    input  logic [2:0]       hall_in,
    input  logic             fault_clr,
    output logic             pwm,
    output logic             dir,
    output logic             brake,
    output logic [2:0]       hall,
    output logic             fault,
    output logic [15:0]      hall_period
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam int               DW_W      = $clog2(BRAKE_PERIODS + 1);
    localparam logic [DW_W-1:0]  DWELL_MIN = DW_W'(BRAKE_PERIODS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_lat;
    logic [DW_W-1:0]  dwell;
    logic             wrap;
    logic             start_run;
    logic             enter_brake;
    logic             leave_brake;
    logic             stalled;
    logic             fault_cond;
    logic             pwm_d;
    logic             brake_d;
    logic             fault_d;

    bldc_hall_monitor #(
        .STALL_CLKS(STALL_CLKS)
    ) u_hall (
        .clk        (clk),
        .rst_n      (rst_n),
        .hall_in    (hall_in),
        .hall       (hall),
        .hall_period(hall_period),
        .stalled    (stalled),
        .fault_cond (fault_cond)
    );

    assign wrap        = (cnt == CNT_LAST);
    assign start_run   = (state == IDLE) && (state_next == RUN);
    assign enter_brake = (state == RUN) && (state_next == BRAKE);
    assign leave_brake = (state == BRAKE) && ((state_next == RUN) || (state_next == IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (fault_cond)                        state_next = FAULT;
                else if (!en)                          state_next = IDLE;
                else if (brake_req || (dir_req != dir)) state_next = BRAKE;
            end
            BRAKE: begin
                if (fault_cond) begin
                    state_next = FAULT;
                end else if ((dwell == DWELL_MIN) && stalled && !brake_req) begin
                    state_next = en ? RUN : IDLE;
                end
            end
            FAULT: begin
                if (fault_clr && !en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that the registered pwm,
    // brake and fault all change on the same clock as the state. pwm also
    // requires the current state to be RUN so that no on-time overlaps a
    // cycle in which dir may be reloaded.
    always_comb begin
        pwm_d   = (state == RUN) && (state_next == RUN) && (cnt < duty_lat);
        brake_d = (state_next == BRAKE) || (state_next == FAULT);
        fault_d = (state_next == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm   <= 1'b0;
            brake <= 1'b0;
            fault <= 1'b0;
        end else begin
            pwm   <= pwm_d;
            brake <= brake_d;
            fault <= fault_d;
        end
    end

    // Restarting the period on brake entry makes the dwell a whole number
    // of full PWM periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start_run || enter_brake || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_lat <= '0;
        end else if (start_run || wrap) begin
            duty_lat <= duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
        end else if (state != BRAKE) begin
            dwell <= '0;
        end else if (wrap && (dwell != DWELL_MIN)) begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= 1'b0;
        end else if (start_run || leave_brake) begin
            dir <= dir_req;
        end
    end

endmodule
